wb_arbiter: RTL

- Shares the register file's single write port (wreg/wdata/wen) between NREQ writeback sources, e.g. ALU, load unit and multi-cycle mul/div.
- Each source holds a valid/ready request. The arbiter grants one request per cycle using round-robin priority.
- The granted write is registered and driven to the register file one cycle after acceptance.
- Sits between the execute/memory units and the register file.

---
 rtl/wb_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Round-robin arbiter sharing the register-file write port between
//             NREQ writeback sources, with a registered write stage.
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*5-1:0]          req_reg,
    input  logic [NREQ*32-1:0]         req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic [4:0]                 wreg,
    output logic [31:0]                wdata,
    output logic                       wen,
    output logic [$clog2(NREQ)-1:0]    wb_src,
    output logic                       err_dup
);

    localparam int c_IDX_W = $clog2(NREQ);

    logic [c_IDX_W-1:0] r_ptr_q,   w_ptr_d;
    logic               r_wen_q,   w_wen_d;
    logic [4:0]         r_wreg_q,  w_wreg_d;
    logic [31:0]        r_wdata_q, w_wdata_d;
    logic [c_IDX_W-1:0] r_src_q,   w_src_d;
    logic               r_err_q,   w_err_d;

    logic [NREQ-1:0]    w_grant;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic               w_found;
    logic               w_dup;
    logic [4:0]         w_sel_reg;
    logic [31:0]        w_sel_data;

    function automatic logic [c_IDX_W-1:0] f_wrap(input int v);
        return c_IDX_W'(v % NREQ);
    endfunction

    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_dup     = 1'b0;

        // Scan from the pointer upward with wrap; reset suppresses every grant.
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_found && req_valid[f_wrap(int'(r_ptr_q) + k)]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = f_wrap(int'(r_ptr_q) + k);
                    w_grant[f_wrap(int'(r_ptr_q) + k)] = 1'b1;
                end
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (req_valid[i] && req_valid[j] &&
                    (req_reg[i*5 +: 5] == req_reg[j*5 +: 5]) &&
                    (req_reg[i*5 +: 5] != 5'd0)) begin
                    w_dup = 1'b1;
                end
            end
        end

        w_sel_reg  = req_reg[w_gnt_idx*5 +: 5];
        w_sel_data = req_data[w_gnt_idx*32 +: 32];

        w_ptr_d = r_ptr_q;
        if (w_found) begin
            w_ptr_d = (w_gnt_idx == c_IDX_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end

        // x0 writes are consumed but never reach the register file.
        w_wen_d   = w_found && (w_sel_reg != 5'd0);
        w_wreg_d  = r_wreg_q;
        w_wdata_d = r_wdata_q;
        w_src_d   = r_src_q;
        if (w_wen_d) begin
            w_wreg_d  = w_sel_reg;
            w_wdata_d = w_sel_data;
            w_src_d   = w_gnt_idx;
        end

        w_err_d = r_err_q | w_dup;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr_q   <= '0;
            r_wen_q   <= 1'b0;
            r_wreg_q  <= '0;
            r_wdata_q <= '0;
            r_src_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_ptr_q   <= w_ptr_d;
            r_wen_q   <= w_wen_d;
            r_wreg_q  <= w_wreg_d;
            r_wdata_q <= w_wdata_d;
            r_src_q   <= w_src_d;
            r_err_q   <= w_err_d;
        end
    end

    assign req_ready = w_grant;
    assign wen       = r_wen_q;
    assign wreg      = r_wreg_q;
    assign wdata     = r_wdata_q;
    assign wb_src    = r_src_q;
    assign err_dup   = r_err_q;

endmodule
`default_nettype wire
